// File: rtl/imem_loader.sv
// Boot-time loader: byte stream -> big-endian 32-bit words -> instruction memory, holding the CPU in reset until done.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CSUM_EN.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    WRITE  = 3'd3,
`ifdef IMEM_LOADER_CSUM_EN
    CSUM   = 3'd4,
`endif
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

  state_t      state_r;
  state_t      state_next_s;
  logic [15:0] count_r;
  logic [15:0] count_s;
  logic [1:0]  byte_idx_r;
  logic [31:0] asm_r;
  logic [15:0] words_r;
  logic        transfer_s;
  logic        byte_ready_r;
  logic        mem_we_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  logic        cpu_hold_r;
  logic        done_r;
  logic        error_r;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]  csum_r;

  // Modulo-256 running sum of data bytes
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction
`endif

  // Ready is a pure function of the state being entered, so it can be registered
  function automatic logic ready_for(input state_t s);
    logic r;
    case (s)
      LEN_HI, LEN_LO, DATA: r = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
      CSUM:                 r = 1'b1;
`endif
      default:              r = 1'b0;
    endcase
    return r;
  endfunction

  assign transfer_s = byte_valid && byte_ready_r;
  assign count_s    = {count_r[15:8], byte_data};

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      LEN_HI: begin
        if (transfer_s) state_next_s = LEN_LO;
        else            state_next_s = state_r;
      end
      LEN_LO: begin
        if (!transfer_s)                       state_next_s = state_r;
        else if ({1'b0, count_s} > MAX_WORDS)  state_next_s = ERROR;
        else if (count_s == 16'd0)
`ifdef IMEM_LOADER_CSUM_EN
                                               state_next_s = CSUM;
`else
                                               state_next_s = DONE;
`endif
        else                                   state_next_s = DATA;
      end
      DATA: begin
        if (transfer_s && byte_idx_r == 2'd3) state_next_s = WRITE;
        else                                   state_next_s = state_r;
      end
      WRITE: begin
        if (({1'b0, words_r} + 17'd1) < {1'b0, count_r}) state_next_s = DATA;
        else
`ifdef IMEM_LOADER_CSUM_EN
          state_next_s = CSUM;
`else
          state_next_s = DONE;
`endif
      end
`ifdef IMEM_LOADER_CSUM_EN
      CSUM: begin
        if (!transfer_s)            state_next_s = state_r;
        else if (byte_data == csum_r) state_next_s = DONE;
        else                        state_next_s = ERROR;
      end
`endif
      DONE:    state_next_s = DONE;
      ERROR:   state_next_s = ERROR;
      default: state_next_s = ERROR;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r      <= LEN_HI;
      count_r      <= 16'd0;
      byte_idx_r   <= 2'd0;
      asm_r        <= 32'd0;
      words_r      <= 16'd0;
      byte_ready_r <= 1'b1;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= 32'd0;
      mem_wdata_r  <= 32'd0;
      cpu_hold_r   <= 1'b1;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_r       <= 8'd0;
`endif
    end else begin
      state_r      <= state_next_s;
      byte_ready_r <= ready_for(state_next_s);
      mem_we_r     <= (state_next_s == WRITE);
      cpu_hold_r   <= (state_next_s != DONE);
      done_r       <= (state_next_s == DONE);
      error_r      <= (state_next_s == ERROR);
      if (transfer_s && state_r == LEN_HI) count_r[15:8] <= byte_data;
      if (transfer_s && state_r == LEN_LO) count_r[7:0]  <= byte_data;
      if (transfer_s && state_r == DATA) begin
        asm_r      <= {asm_r[23:0], byte_data};
        byte_idx_r <= byte_idx_r + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
        csum_r     <= csum_add(csum_r, byte_data);
`endif
      end
      // Capture the write beat as WRITE is entered so the strobe and data line up
      if (state_r == DATA && state_next_s == WRITE) begin
        mem_addr_r  <= {14'd0, words_r, 2'b00};
        mem_wdata_r <= {asm_r[23:0], byte_data};
      end
      if (state_r == WRITE) words_r <= words_r + 16'd1;
    end
  end

  assign byte_ready   = byte_ready_r;
  assign mem_we       = mem_we_r;
  assign mem_addr     = mem_addr_r;
  assign mem_wdata    = mem_wdata_r;
  assign cpu_hold     = cpu_hold_r;
  assign done         = done_r;
  assign error        = error_r;
  assign words_loaded = words_r;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes, a negedge monitor pops and compares.
module tb_imem_loader;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready, mem_we, cpu_hold, done, error;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] words_loaded;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [31:0] load_words[$];
  bit  gaps_en = 1'b0;

  imem_loader #(.ADDR_WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write must be expected, single-cycle and right after a handshake
  bit prev_we = 1'b0;
  bit prev_hs = 1'b0;
  always @(negedge clock) begin
    logic [63:0] e;
    if (mem_we === 1'b1) begin
      chk("we_single_cycle", {31'd0, prev_we}, 32'd0);
      chk("we_latency", {31'd0, prev_hs}, 32'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", mem_addr, e[63:32]);
        chk("write_data", mem_wdata, e[31:0]);
      end
    end
    prev_we = (mem_we === 1'b1);
    prev_hs = (byte_valid === 1'b1) && (byte_ready === 1'b1) && (reset_n === 1'b1);
  end

  task automatic check_idle_state(input string tag);
    chk({tag, "_ready"}, {31'd0, byte_ready}, 32'd1);
    chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd1);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
    chk({tag, "_words"}, {16'd0, words_loaded}, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    byte_valid = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    reset_n = 1'b1;
    check_idle_state("rst");
  endtask

  // Presents a byte and returns once it is guaranteed to transfer on the next edge
  task automatic send_byte(input logic [7:0] b);
    int bound;
    @(posedge clock); #1;
    if (gaps_en) begin
      repeat ($urandom_range(0, 2)) begin
        byte_valid = 1'b0;
        @(posedge clock); #1;
      end
    end
    byte_valid = 1'b1;
    byte_data = b;
    bound = 0;
    while (byte_ready !== 1'b1 && bound < 50) begin
      @(posedge clock); #1;
      bound++;
    end
    if (bound >= 50) chk("ready_timeout", 32'd1, 32'd0);
  endtask

  task automatic end_stream();
    @(posedge clock); #1;
    byte_valid = 1'b0;
  endtask

  task automatic wait_end();
    int bound = 0;
    while (done !== 1'b1 && error !== 1'b1 && bound < 50) begin
      @(posedge clock); #1;
      bound++;
    end
    if (bound >= 50) chk("end_timeout", 32'd1, 32'd0);
  endtask

  // Streams load_words; reference: word i lands at byte address 4*i, checksum is the byte sum mod 256
  task automatic run_load(input string tag, input bit csum_bad);
    int n = load_words.size();
    logic [7:0] sum = 8'd0;
    bit exp_err = 1'b0;
    logic [15:0] n16 = 16'(n);
    send_byte(n16[15:8]);
    send_byte(n16[7:0]);
    for (int i = 0; i < n; i++) begin
      logic [31:0] w = load_words[i];
      exp_q.push_back({32'(i * 4), w});
      for (int k = 3; k >= 0; k--) begin
        send_byte(w[k*8 +: 8]);
        sum = sum + w[k*8 +: 8];
      end
    end
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(csum_bad ? sum - 8'd1 : sum);
    exp_err = csum_bad;
`endif
    end_stream();
    wait_end();
    chk({tag, "_done"}, {31'd0, done}, {31'd0, !exp_err});
    chk({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
    chk({tag, "_hold"}, {31'd0, cpu_hold}, {31'd0, exp_err});
    chk({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
    chk({tag, "_words"}, {16'd0, words_loaded}, 32'(n));
    repeat (2) @(posedge clock);
    #1;
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    // Single word, back-to-back
    gaps_en = 1'b0;
    load_words = '{32'h20080005};
    run_load("one_word", 1'b0);

    // Two words with random gaps
    do_reset();
    gaps_en = 1'b1;
    load_words = '{32'h8C090004, 32'h00000000};
    run_load("two_words", 1'b0);

    // Empty program
    do_reset();
    load_words.delete();
    run_load("n_zero", 1'b0);

    // Oversize count
    do_reset();
    gaps_en = 1'b0;
    send_byte(8'h01);
    send_byte(8'h01);
    @(posedge clock); #1;
    chk("oversize_error", {31'd0, error}, 32'd1);
    chk("oversize_hold", {31'd0, cpu_hold}, 32'd1);
    chk("oversize_ready", {31'd0, byte_ready}, 32'd0);
    byte_data = 8'hA5;
    repeat (8) @(posedge clock);
    #1;
    byte_valid = 1'b0;
    chk("oversize_stuck", {31'd0, error}, 32'd1);
    chk("oversize_done", {31'd0, done}, 32'd0);

`ifdef IMEM_LOADER_CSUM_EN
    do_reset();
    load_words = '{32'h20080005};
    run_load("csum_bad", 1'b1);
`endif

    // Reset after two bytes of the first word
    do_reset();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h20);
    send_byte(8'h08);
    @(posedge clock); #1;
    byte_valid = 1'b0;
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    check_idle_state("midrst");
    load_words = '{32'h20080005};
    run_load("after_rst", 1'b0);

    // Random loads
    for (int t = 0; t < 6; t++) begin
      do_reset();
      gaps_en = ($urandom_range(0, 1) == 1);
      load_words.delete();
      repeat ($urandom_range(1, 7)) load_words.push_back($urandom);
      run_load("rand", 1'b0);
    end

    // Full capacity: last write at (2**8 - 1) * 4
    do_reset();
    gaps_en = 1'b0;
    load_words.delete();
    for (int i = 0; i < 256; i++) load_words.push_back($urandom);
    run_load("full", 1'b0);
    chk("full_last_addr", mem_addr, 32'h000003FC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
